timer_counter: RTL

- Counter stage of the timer IP, directly downstream of the prescaler that produces the divided internal clock.
- Runs entirely on the system clock and treats the prescaler output as a level signal: rising-edge detection turns it into a one-cycle count-enable tick.
- Provides the TCNT value, parallel load from TDR, up/down counting, and sticky overflow/underflow flags for the register/interrupt logic.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_edge_detect.sv | 35 +++
 rtl/timer_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: constants and types shared by the timer counter stage.
//   TIMER_WIDTH : default counter / load-data width
//   CNT_UP/DOWN : encoding of the tc_updown direction input
//   CNT_MAX     : all-ones counter value for the default width
//   cnt_op_e    : the single action the counter takes in a given cycle
package timer_pkg;

    localparam int TIMER_WIDTH = 8;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    localparam logic [TIMER_WIDTH-1:0] CNT_MAX = {TIMER_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/timer_edge_detect.sv
// timer_edge_detect: turns the prescaler's divided-clock level into a
// one-cycle rising-edge indication on the system clock.
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   level : divided clock from the prescaler (already in clk domain)
//   rise  : combinational, high in the cycle level is 1 and was 0 last cycle
//   tick  : rise registered, one-cycle pulse per detected rising edge
module timer_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic tick
);

    logic prev;

    // History resets to 1 so a level already high out of reset is not
    // mistaken for a rising edge. It tracks every cycle, enabled or not,
    // so re-enabling the counter never sees a stale edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b1;
            tick <= 1'b0;
        end else begin
            prev <= level;
            tick <= rise;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/timer_counter.sv
// timer_counter: TCNT counter stage of the timer IP.
//   tc_clk     : system clock
//   tc_reset   : asynchronous, active-high reset
//   tc_clk_in  : divided clock level from the prescaler
//   tc_en      : count enable
//   tc_updown  : 0 = count up, 1 = count down
//   tc_load    : level-sensitive load, tc_cnt follows tc_tdr while high
//   tc_tdr     : load value
//   tc_ovf_clr : clear sticky overflow flag
//   tc_udf_clr : clear sticky underflow flag
//   tc_cnt     : counter value
//   tc_ovf     : sticky overflow flag (set on FF..F -> 0 while counting up)
//   tc_udf     : sticky underflow flag (set on 0 -> FF..F while counting down)
//   tc_tick    : registered one-cycle pulse per tc_clk_in rising edge
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             tc_clk,
    input  logic             tc_reset,
    input  logic             tc_clk_in,
    input  logic             tc_en,
    input  logic             tc_updown,
    input  logic             tc_load,
    input  logic [WIDTH-1:0] tc_tdr,
    input  logic             tc_ovf_clr,
    input  logic             tc_udf_clr,
    output logic [WIDTH-1:0] tc_cnt,
    output logic             tc_ovf,
    output logic             tc_udf,
    output logic             tc_tick
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic    rise;
    logic    cnt_ev;
    logic    ovf_set;
    logic    udf_set;
    cnt_op_e op;

    timer_edge_detect u_edge (
        .clk   (tc_clk),
        .rst   (tc_reset),
        .level (tc_clk_in),
        .rise  (rise),
        .tick  (tc_tick)
    );

    // Load outranks counting; a tick arriving during a load is dropped.
    assign cnt_ev = rise & tc_en & ~tc_load;

    // NOTE: every path assigns op, so no latch is inferred here.
    always_comb begin
        op = OP_HOLD;
        if (tc_load) begin
            op = OP_LOAD;
        end else if (cnt_ev) begin
            op = (tc_updown == CNT_DOWN) ? OP_DOWN : OP_UP;
        end
    end

    assign ovf_set = (op == OP_UP)   && (tc_cnt == MAX_VAL);
    assign udf_set = (op == OP_DOWN) && (tc_cnt == '0);

    always_ff @(posedge tc_clk or posedge tc_reset) begin
        if (tc_reset) begin
            tc_cnt <= '0;
            tc_ovf <= 1'b0;
            tc_udf <= 1'b0;
        end else begin
            unique case (op)
                OP_LOAD: tc_cnt <= tc_tdr;
                OP_UP:   tc_cnt <= tc_cnt + WIDTH'(1);
                OP_DOWN: tc_cnt <= tc_cnt - WIDTH'(1);
                default: tc_cnt <= tc_cnt;
            endcase
            // Set beats a same-cycle clear; load leaves the flags alone.
            tc_ovf <= ovf_set | (tc_ovf & ~tc_ovf_clr);
            tc_udf <= udf_set | (tc_udf & ~tc_udf_clr);
        end
    end

endmodule
